// File: rtl/div_ctrl_pkg.sv
// Shared encodings for the multi-cycle divide sequencer: div_op field positions,
// FSM state encoding and iteration counts.
package div_ctrl_pkg;

  // div_op = {word, rem, unsigned}
  localparam int unsigned DIV_U    = 0;
  localparam int unsigned DIV_REM  = 1;
  localparam int unsigned DIV_W    = 2;
  localparam int unsigned DIV_OP_W = 3;

  localparam int unsigned DIV_ITER_64 = 64;
  localparam int unsigned DIV_ITER_32 = 32;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPrep = 3'd1,
    StCalc = 3'd2,
    StFix  = 3'd3,
    StDone = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring divide iteration: shift {rem, quo}, trial-subtract the divisor
// over XLEN+1 bits and keep the difference when it is non-negative.
module div_step #(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_div,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0] w_rem_sh;
  logic [XLEN:0] w_trial;
  logic          w_ge;

  always_comb begin
    w_rem_sh = {i_rem, i_quo[XLEN-1]};
    w_trial  = w_rem_sh - {1'b0, i_div};
    // Top bit of the extended difference is the borrow: clear means trial >= 0.
    w_ge     = ~w_trial[XLEN];
    o_rem    = w_ge ? w_trial[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    o_quo    = {i_quo[XLEN-2:0], w_ge};
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU/REM/REMU (+W forms) sequencer: valid/ready operand intake,
// restoring divide over one shared subtractor, divide-by-zero and overflow fast paths.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DIV_OP_W-1:0] div_op,
  input  logic [XLEN-1:0]     op1,
  input  logic [XLEN-1:0]     op2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     result,
  input  logic                flush,
  output logic                busy
);

  localparam int unsigned HALF = XLEN / 2;
  localparam int unsigned CntW = $clog2(XLEN + 1);

  div_state_e          r_state;
  div_state_e          w_state_d;
  logic [DIV_OP_W-1:0] r_op;
  logic [XLEN-1:0]     r_op1;
  logic [XLEN-1:0]     r_op2;
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_quo;
  logic [XLEN-1:0]     r_div;
  logic                r_q_neg;
  logic                r_r_neg;
  logic [CntW-1:0]     r_cnt;
  logic [XLEN-1:0]     r_result;
  logic                r_out_valid;
  logic                w_out_valid_d;

  logic            w_accept;
  logic            w_word;
  logic            w_sgn;
  logic            w_sel_rem;
  logic [XLEN-1:0] w_sext_a;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic [XLEN-1:0] w_min;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic [XLEN-1:0] w_step_rem;
  logic [XLEN-1:0] w_step_quo;
  logic [XLEN-1:0] w_q;
  logic [XLEN-1:0] w_r;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;
  logic [XLEN-1:0] w_sel;
  logic [XLEN-1:0] w_fix_res;

  assign in_ready  = (r_state == StIdle) && !flush;
  assign busy      = (r_state != StIdle);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign w_accept  = in_valid && in_ready;

  assign w_word    = r_op[DIV_W];
  assign w_sgn     = !r_op[DIV_U];
  assign w_sel_rem = r_op[DIV_REM];

  // Operand conditioning for PREP: narrowing, magnitudes and special-case detection.
  always_comb begin
    w_sext_a = {{HALF{r_op1[HALF-1]}}, r_op1[HALF-1:0]};
    w_a      = r_op1;
    w_b      = r_op2;
    if (w_word) begin
      w_a = w_sgn ? w_sext_a : {{HALF{1'b0}}, r_op1[HALF-1:0]};
      w_b = w_sgn ? {{HALF{r_op2[HALF-1]}}, r_op2[HALF-1:0]} : {{HALF{1'b0}}, r_op2[HALF-1:0]};
    end
    w_a_neg = w_sgn && w_a[XLEN-1];
    w_b_neg = w_sgn && w_b[XLEN-1];
    w_a_abs = w_a_neg ? -w_a : w_a;
    w_b_abs = w_b_neg ? -w_b : w_b;
    w_min   = w_word ? {{(HALF + 1){1'b1}}, {(HALF - 1){1'b0}}}
                     : {1'b1, {(XLEN - 1){1'b0}}};
    w_div0  = (w_b == '0);
    w_ovf   = w_sgn && (w_a == w_min) && (w_b == '1);
    w_special     = w_div0 || w_ovf;
    w_special_res = '0;
    if (w_div0) begin
      w_special_res = w_sel_rem ? (w_word ? w_sext_a : r_op1) : '1;
    end else if (w_ovf) begin
      w_special_res = w_sel_rem ? '0 : (w_word ? w_sext_a : r_op1);
    end
  end

  div_step #(
    .XLEN (XLEN)
  ) u_div_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_step_rem),
    .o_quo (w_step_quo)
  );

  // Sign fix-up and result selection for FIX.
  always_comb begin
    w_q       = w_word ? {{HALF{1'b0}}, r_quo[HALF-1:0]} : r_quo;
    w_r       = r_rem;
    w_q_fix   = r_q_neg ? -w_q : w_q;
    w_r_fix   = r_r_neg ? -w_r : w_r;
    w_sel     = w_sel_rem ? w_r_fix : w_q_fix;
    w_fix_res = w_word ? {{HALF{w_sel[HALF-1]}}, w_sel[HALF-1:0]} : w_sel;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_d = StPrep;
      StPrep:  w_state_d = w_special ? StDone : StCalc;
      StCalc:  if (r_cnt == CntW'(1)) w_state_d = StFix;
      StFix:   w_state_d = StDone;
      StDone:  if (r_out_valid && out_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (flush) w_state_d = StIdle;
  end

  // out_valid rises one cycle into DONE and drops on handoff or flush.
  assign w_out_valid_d = (r_state == StDone) && !flush && !(r_out_valid && out_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_cnt       <= '0;
      r_op        <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_out_valid <= w_out_valid_d;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_op  <= div_op;
            r_op1 <= op1;
            r_op2 <= op2;
          end
        end
        StPrep: begin
          r_q_neg <= w_a_neg ^ w_b_neg;
          r_r_neg <= w_a_neg;
          r_rem   <= '0;
          r_div   <= w_b_abs;
          // W dividends sit in the upper half so their bits shift into rem first.
          r_quo   <= w_word ? {w_a_abs[HALF-1:0], {HALF{1'b0}}} : w_a_abs;
          r_cnt   <= w_word ? CntW'(DIV_ITER_32) : CntW'(DIV_ITER_64);
          if (w_special) r_result <= w_special_res;
        end
        StCalc: begin
          r_rem <= w_step_rem;
          r_quo <= w_step_quo;
          r_cnt <= r_cnt - CntW'(1);
        end
        StFix:   r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl: arithmetic results, latencies,
// backpressure, flush and reset behaviour against hand-computed values.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  div_op;
  logic [63:0] op1;
  logic [63:0] op2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        flush;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [2:0] OpDiv   = 3'b000;
  localparam logic [2:0] OpDivu  = 3'b001;
  localparam logic [2:0] OpRem   = 3'b010;
  localparam logic [2:0] OpRemu  = 3'b011;
  localparam logic [2:0] OpDivw  = 3'b100;
  localparam logic [2:0] OpDivuw = 3'b101;
  localparam logic [2:0] OpRemw  = 3'b110;

  always #5 clk = ~clk;

  div_ctrl #(
    .XLEN (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .div_op    (div_op),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flush     (flush),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; returns at a negedge after handoff.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int exp_lat,
                       input int hold);
    int lat;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    div_op    = op;
    op1       = a;
    op2       = b;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
      if (lat == 1) begin
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        chk({tag, ".in_ready_busy"}, 64'(in_ready), 64'd0);
      end
    end
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".result"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".hold_result"}, result, exp);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".post_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".post_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int seen;
    rst       = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    div_op    = '0;
    op1       = '0;
    op2       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.result", result, 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst.in_ready", 64'(in_ready), 64'd1);

    do_op("divu_100_7", OpDivu, 64'd100, 64'd7, 64'd14, 67, 0);
    do_op("div_m7_2", OpDiv, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67, 0);
    do_op("rem_m7_2", OpRem, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67, 0);
    do_op("divu_max_10", OpDivu, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'h1999_9999_9999_9999,
          67, 0);
    do_op("remu_max_10", OpRemu, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'd5, 67, 0);
    do_op("divu_5_0", OpDivu, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
    do_op("remu_5_0", OpRemu, 64'd5, 64'd0, 64'd5, 2, 0);
    do_op("remw_0", OpRemw, 64'h0000_0001_FFFF_FFF8, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 2, 0);
    do_op("div_ovf", OpDiv, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 2, 0);
    do_op("rem_ovf", OpRem, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2, 0);
    do_op("divw_m8_3", OpDivw, 64'h0000_0001_FFFF_FFF8, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 35, 0);
    do_op("divuw_ff_1", OpDivuw, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 35,
          0);

    // Backpressure, then a back-to-back op accepted one cycle after handoff.
    do_op("bp_divu", OpDivu, 64'd100, 64'd7, 64'd14, 67, 10);
    do_op("b2b_divw", OpDivw, 64'd20, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFC, 35, 0);

    // Flush during the 10th CALC cycle.
    in_valid = 1'b1;
    div_op   = OpDivu;
    op1      = 64'd1000;
    op2      = 64'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("flush.busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush.busy_after", 64'(busy), 64'd0);
    chk("flush.in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush.no_valid", 64'(seen), 64'd0);

    // Reset in mid-CALC clears outputs (result was 0x..FC beforehand).
    in_valid = 1'b1;
    div_op   = OpDivu;
    op1      = 64'd77;
    op2      = 64'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("mrst.busy_before", 64'(busy), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mrst.busy", 64'(busy), 64'd0);
    chk("mrst.out_valid", 64'(out_valid), 64'd0);
    chk("mrst.result", result, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Flush alongside in_valid in IDLE must not accept.
    in_valid = 1'b1;
    flush    = 1'b1;
    div_op   = OpDivu;
    op1      = 64'd9;
    op2      = 64'd0;
    #1 chk("fidle.in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("fidle.busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    chk("fidle.quiet", 64'(seen), 64'd0);

    do_op("after_rst", OpRemu, 64'd77, 64'd5, 64'd2, 67, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
